// File: rtl/sw_transport_pkg.sv
// Shared types and elaboration helpers for the switch-to-data transport.
package sw_transport_pkg;

    // Handshake state: IDLE has nothing to offer, PEND holds an undelivered word.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } xfer_state_t;

    // True when the switch bank fits in the output word and is non-empty.
    function automatic bit width_ok(input int sw_w, input int data_w);
        return (sw_w >= 1) && (data_w >= sw_w);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch synchroniser and debouncer: emits a one-cycle event when a new
// value has been stable long enough and differs from the last accepted one.
module sw_debounce
    import sw_transport_pkg::*;
#(
    parameter int SW_W      = 3,
    parameter int DEBOUNCE  = 4,
    parameter int HOLD_ZERO = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw,
    output logic [SW_W-1:0] stable_o,
    output logic            event_o
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_QUAL = CNT_W'(DEBOUNCE - 1);

    logic [SW_W-1:0]  sync1_d, sync1_q;
    logic [SW_W-1:0]  sw_s_d, sw_s_q;
    logic [SW_W-1:0]  sw_prev_d, sw_prev_q;
    logic [SW_W-1:0]  stable_d, stable_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             qualify_s;
    logic             event_s;

    // Next-state logic: synchroniser shift, stability counter, acceptance.
    always_comb begin
        sync1_d   = sw;
        sw_s_d    = sync1_q;
        sw_prev_d = sw_s_q;

        if (sw_s_q != sw_prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // Qualify fires exactly once per settled value because cnt saturates above it.
        qualify_s = (cnt_q == CNT_QUAL) && (sw_s_q == sw_prev_q);

        stable_d = stable_q;
        event_s  = 1'b0;
        if (qualify_s && (sw_prev_q != stable_q)) begin
            stable_d = sw_prev_q;
            if ((HOLD_ZERO != 0) && (sw_prev_q == '0)) begin
                event_s = 1'b0;
            end else begin
                event_s = 1'b1;
            end
        end else begin
            stable_d = stable_q;
        end
    end

    // State registers; everything restarts from zero on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sw_s_q    <= '0;
            sw_prev_q <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sw_s_q    <= sw_s_d;
            sw_prev_q <= sw_prev_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
        end
    end

    // The accepted value is presented in the same cycle as its event so the
    // consumer loads it on the edge that commits it.
    assign stable_o = stable_d;
    assign event_o  = event_s;

endmodule

// File: rtl/sw_transport.sv
// Top level: debounced switch value delivered over valid/ready with
// sticky overrun reporting.
module sw_transport
    import sw_transport_pkg::*;
#(
    parameter int SW_W      = 3,
    parameter int DATA_W    = 8,
    parameter int DEBOUNCE  = 4,
    parameter int HOLD_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   sw,
    input  logic              ready,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              overrun
);

    generate
        if (!width_ok(SW_W, DATA_W)) begin : g_width_chk
            $error("sw_transport: DATA_W must be >= SW_W >= 1");
        end
    endgenerate

    logic [SW_W-1:0]   stable_s;
    logic              event_s;
    logic [DATA_W-1:0] ext_s;
    xfer_state_t       state_d, state_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_d, valid_q;
    logic              overrun_d, overrun_q;
    logic              ovr_set_s;

    sw_debounce #(
        .SW_W      (SW_W),
        .DEBOUNCE  (DEBOUNCE),
        .HOLD_ZERO (HOLD_ZERO)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .stable_o (stable_s),
        .event_o  (event_s)
    );

    // Handshake next-state: load on event, drop valid once consumed.
    always_comb begin
        ext_s              = '0;
        ext_s[SW_W-1:0]    = stable_s;
        state_d            = state_q;
        data_d             = data_q;
        ovr_set_s          = 1'b0;

        case (state_q)
            IDLE: begin
                if (event_s) begin
                    data_d  = ext_s;
                    state_d = PEND;
                end else begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                if (event_s) begin
                    // A value consumed on this edge is not lost, so only an
                    // unconsumed replacement counts as overrun.
                    data_d    = ext_s;
                    state_d   = PEND;
                    ovr_set_s = !ready;
                end else if (ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = PEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == PEND);

        // Set has priority over clear so a fresh overrun is never hidden.
        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Output and state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sw_transport.sv
// Directed bench for sw_transport: inputs change and outputs are sampled
// on the falling clock edge.
module tb_sw_transport;

    logic       clk;
    logic       rst;
    logic [2:0] sw;
    logic       ready;
    logic       ovr_clr;
    logic [7:0] data;
    logic       valid;
    logic       overrun;

    logic [2:0] sw2;
    logic       ready2;
    logic [7:0] data2;
    logic       valid2;
    logic       overrun2;

    int checks_cnt;
    int errors_cnt;

    sw_transport #(
        .SW_W(3), .DATA_W(8), .DEBOUNCE(4), .HOLD_ZERO(1)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw), .ready(ready), .ovr_clr(ovr_clr),
        .data(data), .valid(valid), .overrun(overrun)
    );

    sw_transport #(
        .SW_W(3), .DATA_W(8), .DEBOUNCE(4), .HOLD_ZERO(0)
    ) dut_hz0 (
        .clk(clk), .rst(rst), .sw(sw2), .ready(ready2), .ovr_clr(ovr_clr),
        .data(data2), .valid(valid2), .overrun(overrun2)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst     = 1'b1;
        sw      = 3'd0;
        ready   = 1'b0;
        ovr_clr = 1'b0;
        sw2     = 3'd0;
        ready2  = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_val("rst_data",    32'(data),    32'h0);
        check_val("rst_valid",   32'(valid),   32'h0);
        check_val("rst_overrun", 32'(overrun), 32'h0);
        step(2);
        rst = 1'b1;

        // Deliver 5: first sample on the next rising edge, valid six edges later.
        step(1);
        sw = 3'd5;
        step(6);
        check_val("lat_valid_early", 32'(valid), 32'h0);
        step(1);
        check_val("lat_valid", 32'(valid),   32'h1);
        check_val("lat_data",  32'(data),    32'h05);
        check_val("lat_ovr",   32'(overrun), 32'h0);

        // Glitch to 2 sampled on only four edges is rejected.
        sw = 3'd2;
        step(4);
        sw = 3'd5;
        step(10);
        check_val("glitch_valid", 32'(valid),   32'h1);
        check_val("glitch_data",  32'(data),    32'h05);
        check_val("glitch_ovr",   32'(overrun), 32'h0);

        // Unconsumed 5 replaced by 7 -> overrun, then cleared.
        sw = 3'd7;
        step(7);
        check_val("ovr_data",  32'(data),    32'h07);
        check_val("ovr_valid", 32'(valid),   32'h1);
        check_val("ovr_set",   32'(overrun), 32'h1);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        check_val("ovr_clr", 32'(overrun), 32'h0);
        check_val("ovr_clr_data", 32'(data), 32'h07);

        // Consume 7.
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        check_val("drain_valid", 32'(valid), 32'h0);
        check_val("drain_data",  32'(data),  32'h07);

        // Hold-zero: deliver 6, settle 0 (silent), settle 6 again (event).
        sw = 3'd6;
        step(7);
        check_val("hz_6_valid", 32'(valid), 32'h1);
        check_val("hz_6_data",  32'(data),  32'h06);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        check_val("hz_6_drain", 32'(valid), 32'h0);
        sw = 3'd0;
        step(10);
        check_val("hz_0_valid", 32'(valid), 32'h0);
        check_val("hz_0_data",  32'(data),  32'h06);
        sw = 3'd6;
        step(7);
        check_val("hz_6b_valid", 32'(valid), 32'h1);
        check_val("hz_6b_data",  32'(data),  32'h06);
        ready = 1'b1;
        step(1);
        ready = 1'b0;

        // Ready coincides with a new event load: valid stays, no overrun.
        sw = 3'd3;
        step(7);
        check_val("co_3_data", 32'(data), 32'h03);
        sw = 3'd1;
        step(6);
        ready = 1'b1;
        step(1);
        check_val("co_valid", 32'(valid),   32'h1);
        check_val("co_data",  32'(data),    32'h01);
        check_val("co_ovr",   32'(overrun), 32'h0);
        step(1);
        ready = 1'b0;
        check_val("co_drop", 32'(valid), 32'h0);

        // Build up a pending value with overrun, then reset mid-operation.
        sw = 3'd3;
        step(7);
        sw = 3'd2;
        step(7);
        check_val("pre_rst_data", 32'(data),    32'h02);
        check_val("pre_rst_ovr",  32'(overrun), 32'h1);
        #2 rst = 1'b0;
        #1;
        check_val("arst_data",  32'(data),    32'h0);
        check_val("arst_valid", 32'(valid),   32'h0);
        check_val("arst_ovr",   32'(overrun), 32'h0);
        sw = 3'd3;
        step(2);
        rst = 1'b1;
        step(6);
        check_val("post_rst_early", 32'(valid), 32'h0);
        step(1);
        check_val("post_rst_valid", 32'(valid), 32'h1);
        check_val("post_rst_data",  32'(data),  32'h03);

        // HOLD_ZERO=0 instance delivers zero like any other value.
        sw2 = 3'd4;
        step(7);
        check_val("hz0_4_valid", 32'(valid2), 32'h1);
        check_val("hz0_4_data",  32'(data2),  32'h04);
        ready2 = 1'b1;
        step(1);
        ready2 = 1'b0;
        check_val("hz0_drain", 32'(valid2), 32'h0);
        sw2 = 3'd0;
        step(7);
        check_val("hz0_0_valid", 32'(valid2), 32'h1);
        check_val("hz0_0_data",  32'(data2),  32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
